uart_rx_fifo: RTL

Receive-side buffer sitting directly downstream of the `uart` core's RX path. It detects each completed frame from the core's `o_rx_busy` falling edge and captures the received word with its error flag into a circular FIFO. It presents a pop/valid read port to the register/bus layer, plus occupancy and sticky overflow status. Host reads are decoupled from the serial line, so back-to-back frames are not lost while software is slow.

---
 rtl/uart_pkg.sv | 17 +
 rtl/fifo_mem.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, RX entry layout
// and pointer sizing helper.
package uart_pkg;

  localparam int WORD_WIDTH    = 8;
  localparam int RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write port,
// registered read port that holds between reads.
import uart_pkg::*;

module fifo_mem #(
  parameter int G_WIDTH = 9,
  parameter int G_DEPTH = 16,
  localparam int AW     = ptr_width(G_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [G_WIDTH-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [G_WIDTH-1:0] o_rd_data
);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [G_WIDTH-1:0] rd_data_q;
  logic [G_WIDTH-1:0] rd_data_d;

  // Next read register value: load on read, else hold
  always_comb begin
    rd_data_d = rd_data_q;
    if (i_rd_en) rd_data_d = mem_q[i_rd_addr];
  end

  // Storage array is intentionally not reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Read data register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// RX buffer: captures each completed UART frame on the busy
// falling edge into a circular FIFO with pop/valid read port.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int G_WORD_WIDTH   = WORD_WIDTH,
  parameter int G_DEPTH        = RX_FIFO_DEPTH,
  parameter bit G_DROP_ERRORED = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [G_WORD_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_busy,
  input  logic                    i_rx_error,
  input  logic                    i_rd_en,
  output logic [G_WORD_WIDTH-1:0] o_rd_data,
  output logic                    o_rd_err,
  output logic                    o_rd_valid,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(G_DEPTH):0] o_count,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow
);

  localparam int PW = ptr_width(G_DEPTH);
  localparam int CW = $clog2(G_DEPTH) + 1;
  localparam int EW = G_WORD_WIDTH + 1;

  logic          busy_prev_q, busy_prev_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          empty, full;
  logic          push_req, push, pop, ovf_set;
  logic [EW-1:0] rd_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(G_DEPTH));

  // Frame detect, push/pop arbitration and next-state
  always_comb begin
    busy_prev_d = i_rx_busy;
    push_req    = busy_prev_q & ~i_rx_busy
                & ~(G_DROP_ERRORED & i_rx_error);
    pop         = i_rd_en & ~empty;
    push        = push_req & (~full | pop);
    ovf_set     = push_req & full & ~pop;
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = pop;
    ovf_d   = ovf_q;
    if (ovf_set)             ovf_d = 1'b1;
    else if (i_clr_overflow) ovf_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      busy_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      busy_prev_q <= busy_prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  fifo_mem #(
    .G_WIDTH (EW),
    .G_DEPTH (G_DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (push),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data ({i_rx_error, i_rx_data}),
    .i_rd_en   (pop),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (rd_entry)
  );

  assign o_rd_data  = rd_entry[G_WORD_WIDTH-1:0];
  assign o_rd_err   = rd_entry[G_WORD_WIDTH];
  assign o_rd_valid = valid_q;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
